harmonic_product_spectrum_multi: RTL

- Parametrised harmonic product spectrum (HPS) engine.
- Buffers one frame of magnitude-spectrum bins, then streams P[i] = X[i]·X[2i]·…·X[N_HARM·i].
- Reports the peak product and its bin index once per frame.
- Sits after the FFT magnitude stage and feeds the pitch estimator. Adds a configurable harmonic count, frame length, DC exclusion and frame framing via last.

---
 rtl/hps_pkg.sv | 26 ++
 rtl/axis_if.sv | 13 +
 rtl/hps_frame_buffer.sv | 39 +++
 rtl/harmonic_product_spectrum_multi.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hps_pkg.sv
// Shared constants and width helpers for the harmonic product spectrum engine.
// FSM state codes plus derived output, count and index widths.
package hps_pkg;

    // FSM state codes
    localparam logic [1:0] LOAD     = 2'd0;
    localparam logic [1:0] COMPUTE  = 2'd1;
    localparam logic [1:0] EMIT_MAX = 2'd2;

    function automatic int hps_out_w(input int in_w, input int n_harm);
        return in_w * n_harm;
    endfunction

    function automatic int hps_n_out(input int n_bins, input int n_harm);
        return (n_bins - 1) / n_harm + 1;
    endfunction

    function automatic int hps_idx_w(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

    function automatic int hps_addr_w(input int n_bins);
        return (n_bins > 1) ? $clog2(n_bins) : 1;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream style handshake bundle: valid/ready/data/last.
// master drives valid/data/last, slave drives ready.
interface Axis_If #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/hps_frame_buffer.sv
// Frame buffer: dual-port RAM with registered read and per-entry valid bits.
// Ports: clr (drop all valid bits), we/waddr/wdata, re/raddr, rdata.
module hps_frame_buffer #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (clr)
            vld <= '0;
        else if (we)
            vld[waddr] <= 1'b1;
    end

    // Bins not written this frame read back as zero.
    always_ff @(posedge clk) begin
        if (re)
            rdata <= vld[raddr] ? mem[raddr] : '0;
    end

endmodule

// File: rtl/harmonic_product_spectrum_multi.sv
// HPS engine: buffers a frame, streams P[i] = prod X[i*k], reports the peak.
// Ports: clk, reset, din (bins), dout (products), max (peak), max_bin.
module harmonic_product_spectrum_multi
    import hps_pkg::*;
#(
    parameter int IN_WIDTH = 24,
    parameter int N_HARM   = 2,
    parameter int N_BINS   = 1024,
    parameter int SKIP_DC  = 1,
    localparam int OUT_WIDTH = hps_out_w(IN_WIDTH, N_HARM),
    localparam int N_OUT     = hps_n_out(N_BINS, N_HARM),
    localparam int IDX_WIDTH = hps_idx_w(N_OUT)
) (
    input  logic                 clk,
    input  logic                 reset,
    Axis_If.slave                din,
    Axis_If.master               dout,
    Axis_If.master               max,
    output logic [IDX_WIDTH-1:0] max_bin
);

    localparam int AW = hps_addr_w(N_BINS);
    localparam int KW = $clog2(N_HARM + 1);
    localparam logic [AW-1:0]        LAST_BIN = AW'(N_BINS - 1);
    localparam logic [AW-1:0]        LAST_I   = AW'(N_OUT - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_OUT = IDX_WIDTH'(N_OUT - 1);
    localparam logic [KW-1:0]        LAST_K   = KW'(N_HARM);
    localparam logic [IDX_WIDTH-1:0] DEF_BIN  =
        IDX_WIDTH'((SKIP_DC != 0) ? 1 : 0);

    logic [1:0]           state;
    logic [AW-1:0]        wr_cnt;
    logic                 iss_busy;
    logic [KW-1:0]        iss_k;
    logic [AW-1:0]        iss_i;
    logic [AW-1:0]        iss_addr;
    logic                 d_vld;
    logic                 d_first;
    logic                 d_last;
    logic [IN_WIDTH-1:0]  rd_data;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] prod;
    logic                 dout_valid;
    logic [OUT_WIDTH-1:0] dout_data;
    logic [IDX_WIDTH-1:0] out_i;
    logic [OUT_WIDTH-1:0] run_max;
    logic [IDX_WIDTH-1:0] run_bin;
    logic [OUT_WIDTH-1:0] max_val;
    logic                 stall;
    logic                 adv;
    logic                 din_hs;
    logic                 dout_hs;
    logic                 max_hs;
    logic                 frame_end;
    logic                 upd;

    assign stall     = dout_valid && !dout.ready;
    assign adv       = (state == COMPUTE) && !stall;
    assign din_hs    = din.valid && din.ready;
    assign dout_hs   = dout_valid && dout.ready;
    assign max_hs    = (state == EMIT_MAX) && max.ready;
    assign frame_end = din_hs && (din.last || wr_cnt == LAST_BIN);
    assign prod      = acc * OUT_WIDTH'(rd_data);
    // Strict compare keeps the lowest index on ties.
    assign upd = dout_hs && !(SKIP_DC != 0 && out_i == '0)
                 && dout_data > run_max;

    assign din.ready  = (state == LOAD) && !reset;
    assign dout.valid = dout_valid;
    assign dout.data  = dout_data;
    assign dout.last  = dout_valid && out_i == LAST_OUT;
    assign max.valid  = (state == EMIT_MAX);
    assign max.data   = max_val;
    assign max.last   = 1'b1;

    hps_frame_buffer #(
        .WIDTH (IN_WIDTH),
        .DEPTH (N_BINS),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .clr   (reset || max_hs),
        .we    (din_hs),
        .waddr (wr_cnt),
        .wdata (din.data),
        .re    (adv),
        .raddr (iss_addr),
        .rdata (rd_data)
    );

    // Address generator: i*k built by adding i once per harmonic.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_busy <= 1'b0;
            iss_k    <= KW'(1);
            iss_i    <= '0;
            iss_addr <= '0;
        end else if (frame_end) begin
            iss_busy <= 1'b1;
            iss_k    <= KW'(1);
            iss_i    <= '0;
            iss_addr <= '0;
        end else if (adv && iss_busy) begin
            if (iss_k == LAST_K) begin
                iss_k    <= KW'(1);
                iss_i    <= iss_i + AW'(1);
                iss_addr <= iss_i + AW'(1);
                if (iss_i == LAST_I)
                    iss_busy <= 1'b0;
            end else begin
                iss_k    <= iss_k + KW'(1);
                iss_addr <= iss_addr + iss_i;
            end
        end
    end

    // Tags travelling with the registered RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_vld   <= 1'b0;
            d_first <= 1'b0;
            d_last  <= 1'b0;
        end else if (adv) begin
            d_vld   <= iss_busy;
            d_first <= (iss_k == KW'(1));
            d_last  <= (iss_k == LAST_K);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
        end else begin
            if (adv && d_vld)
                acc <= d_first ? OUT_WIDTH'(rd_data) : prod;
            if (adv && d_vld && d_last) begin
                dout_valid <= 1'b1;
                dout_data  <= prod;
            end else if (dout_hs) begin
                dout_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD;
            wr_cnt  <= '0;
            out_i   <= '0;
            run_max <= '0;
            run_bin <= DEF_BIN;
            max_val <= '0;
            max_bin <= '0;
        end else begin
            unique case (1'b1)
                (state == LOAD): begin
                    if (din_hs)
                        wr_cnt <= frame_end ? '0 : wr_cnt + AW'(1);
                    if (frame_end) begin
                        state <= COMPUTE;
                        out_i <= '0;
                    end
                end
                (state == COMPUTE): begin
                    if (dout_hs) begin
                        out_i <= out_i + IDX_WIDTH'(1);
                        if (upd) begin
                            run_max <= dout_data;
                            run_bin <= out_i;
                        end
                        if (out_i == LAST_OUT) begin
                            state   <= EMIT_MAX;
                            max_val <= upd ? dout_data : run_max;
                            max_bin <= upd ? out_i : run_bin;
                        end
                    end
                end
                (state == EMIT_MAX): begin
                    if (max.ready) begin
                        state   <= LOAD;
                        run_max <= '0;
                        run_bin <= DEF_BIN;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
